xgmii_frame_gen_32b: RTL

- XGMII transmitter/traffic source for the 32-bit 10GBASE-R datapath.
- Produces complete Ethernet-style frames on xgmii32_t: start, preamble/SFD, patterned payload, terminate, inter-packet gap.
- Drives pcs_tx_32b in place of the retransmit FIFO output, for link bring-up and BER/frame checks against pcs_rx_32b on the far end.
- Runs in the PCS TX clock domain (pma_tx_clk).

---
 rtl/gtype.sv | 39 +++
 rtl/prbs31_32b.sv | 23 ++
 rtl/xgmii_frame_gen_32b.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/gtype.sv
// Shared XGMII types and constants for the 32-bit 10GBASE-R datapath.
package gtype;

  // One 32-bit XGMII beat: lane i = data[8i+7:8i] with ctrl[i]; lane 0 goes first.
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  ctrl;
  } xgmii32_t;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_PRE   = 8'h55;
  localparam logic [7:0] XGMII_SFD   = 8'hD5;

  localparam xgmii32_t XGMII_IDLE_WORD = '{data: {4{XGMII_IDLE}}, ctrl: 4'b1111};
  localparam xgmii32_t XGMII_SOF_WORD  = '{data: {{3{XGMII_PRE}}, XGMII_START}, ctrl: 4'b0001};
  localparam xgmii32_t XGMII_PRE_WORD  = '{data: {XGMII_SFD, {3{XGMII_PRE}}}, ctrl: 4'b0000};
  localparam xgmii32_t XGMII_TERM_WORD = '{data: {{3{XGMII_IDLE}}, XGMII_TERM}, ctrl: 4'b1111};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_PRE,
    ST_DATA,
    ST_TERM,
    ST_IPG
  } xgmii_gen_state_t;

  // Limit a requested payload length to the [lo, hi] window.
  function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                            input logic [15:0] lo,
                                            input logic [15:0] hi);
    if (len < lo) return lo;
    if (len > hi) return hi;
    return len;
  endfunction

endpackage

// File: rtl/prbs31_32b.sv
// PRBS31 (x^31 + x^28 + 1) generator: advances the LFSR by 32 bits in one cycle.
// data_out[n] is the n-th bit produced, so bit 0 is the oldest.
module prbs31_32b (
  input  logic [30:0] state_in,
  output logic [30:0] state_out,
  output logic [31:0] data_out
);

  // Unroll 32 serial shifts of the Fibonacci LFSR.
  always_comb begin
    logic [30:0] s;
    logic        fb;
    s        = state_in;
    data_out = '0;
    for (int n = 0; n < 32; n++) begin
      fb          = s[30] ^ s[27];
      data_out[n] = fb;
      s           = {s[29:0], fb};
    end
    state_out = s;
  end

endmodule

// File: rtl/xgmii_frame_gen_32b.sv
// XGMII 32-bit frame generator: SOF, preamble/SFD, patterned payload,
// terminate and inter-packet gap, repeated for a frame count or until stop.
// Optional macro XGMII_FRAME_GEN_PRBS_EN selects a PRBS31 payload instead of
// the incrementing byte pattern.
module xgmii_frame_gen_32b
  import gtype::*;
#(
  parameter int unsigned MIN_LEN   = 64,
  parameter int unsigned MAX_LEN   = 9600,
  parameter int unsigned IPG_WORDS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic [15:0] frame_len,
  input  logic [15:0] frame_cnt,
  input  logic [7:0]  seed,
  output xgmii32_t    xgmii_tx,
  output logic        busy,
  output logic        done,
  output logic [31:0] frames_sent
);

  xgmii_gen_state_t state_reg, state_next;
  logic [15:0] words_reg, words_next;   // DATA words in this frame
  logic [1:0]  rem_reg, rem_next;       // length mod 4
  logic [15:0] cnt_reg, cnt_next;       // frames still to send
  logic        cont_reg, cont_next;     // continuous mode
  logic [7:0]  seed_reg, seed_next;
  logic [15:0] widx_reg, widx_next;     // current DATA word index
  logic [7:0]  ipg_reg, ipg_next;
  logic        stop_reg, stop_next;
  xgmii32_t    tx_reg, tx_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic [31:0] fs_reg, fs_next;

  logic [15:0] len_clamped;
  logic        last_word;
  logic        partial;
  logic [7:0]  pay_byte  [4];
  logic [7:0]  lane_byte [4];
  logic        lane_ctrl [4];
  xgmii32_t    data_word;

  assign len_clamped = clamp_len(frame_len, 16'(MIN_LEN), 16'(MAX_LEN));
  assign last_word   = (widx_reg == words_reg - 16'd1);
  // The last DATA word of a non-multiple-of-4 frame carries the terminate.
  assign partial     = last_word && (rem_reg != 2'd0);

`ifdef XGMII_FRAME_GEN_PRBS_EN
  logic [30:0] lfsr_reg, lfsr_next, lfsr_step;
  logic [31:0] prbs_data;

  prbs31_32b u_prbs (
    .state_in (lfsr_reg),
    .state_out(lfsr_step),
    .data_out (prbs_data)
  );

  // Reseed at every SOF, advance once per emitted DATA word.
  always_comb begin
    lfsr_next = lfsr_reg;
    if (!pause) begin
      if (state_reg == ST_SOF)
        lfsr_next = {23'h7FFFFF, seed_reg};
      else if (state_reg == ST_DATA)
        lfsr_next = lfsr_step;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_reg <= '1;
    else      lfsr_reg <= lfsr_next;
  end
`endif

  // Per-lane payload byte and terminate/idle substitution.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [2:0] LANE = 3'(gi);
`ifdef XGMII_FRAME_GEN_PRBS_EN
      assign pay_byte[gi] = prbs_data[8*gi +: 8];
`else
      assign pay_byte[gi] = seed_reg + {widx_reg[5:0], 2'b00} + 8'(gi);
`endif
      assign lane_byte[gi] = (!partial || LANE < {1'b0, rem_reg}) ? pay_byte[gi] :
                             (LANE == {1'b0, rem_reg})            ? XGMII_TERM  :
                                                                    XGMII_IDLE;
      assign lane_ctrl[gi] = partial && (LANE >= {1'b0, rem_reg});
    end
  endgenerate

  assign data_word.data = {lane_byte[3], lane_byte[2], lane_byte[1], lane_byte[0]};
  assign data_word.ctrl = {lane_ctrl[3], lane_ctrl[2], lane_ctrl[1], lane_ctrl[0]};

  // Next-state and output decode; pause freezes everything including done.
  always_comb begin
    state_next = state_reg;
    words_next = words_reg;
    rem_next   = rem_reg;
    cnt_next   = cnt_reg;
    cont_next  = cont_reg;
    seed_next  = seed_reg;
    widx_next  = widx_reg;
    ipg_next   = ipg_reg;
    stop_next  = stop_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
    fs_next    = fs_reg;
    if (!pause) begin
      tx_next   = XGMII_IDLE_WORD;
      done_next = 1'b0;
      if (state_reg != ST_IDLE) stop_next = stop_reg | stop;
      case (state_reg)
        ST_IDLE: begin
          stop_next = 1'b0;
          // A simultaneous stop cancels the start.
          if (start && !stop) begin
            state_next = ST_SOF;
            busy_next  = 1'b1;
            words_next = (len_clamped >> 2) + {15'd0, |len_clamped[1:0]};
            rem_next   = len_clamped[1:0];
            cnt_next   = frame_cnt;
            cont_next  = (frame_cnt == 16'd0);
            seed_next  = seed;
          end
        end
        ST_SOF: begin
          tx_next    = XGMII_SOF_WORD;
          state_next = ST_PRE;
        end
        ST_PRE: begin
          tx_next    = XGMII_PRE_WORD;
          widx_next  = '0;
          state_next = ST_DATA;
        end
        ST_DATA: begin
          tx_next   = data_word;
          widx_next = widx_reg + 16'd1;
          if (last_word) begin
            if (rem_reg == 2'd0) begin
              state_next = ST_TERM;
            end else begin
              fs_next    = fs_reg + 32'd1;
              ipg_next   = '0;
              state_next = ST_IPG;
            end
          end
        end
        ST_TERM: begin
          tx_next    = XGMII_TERM_WORD;
          fs_next    = fs_reg + 32'd1;
          ipg_next   = '0;
          state_next = ST_IPG;
        end
        ST_IPG: begin
          if (ipg_reg == 8'(IPG_WORDS - 1)) begin
            if (stop_reg || stop || (!cont_reg && cnt_reg == 16'd1)) begin
              state_next = ST_IDLE;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end else begin
              if (!cont_reg) cnt_next = cnt_reg - 16'd1;
              state_next = ST_SOF;
            end
          end else begin
            ipg_next = ipg_reg + 8'd1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      words_reg <= '0;
      rem_reg   <= '0;
      cnt_reg   <= '0;
      cont_reg  <= 1'b0;
      seed_reg  <= '0;
      widx_reg  <= '0;
      ipg_reg   <= '0;
      stop_reg  <= 1'b0;
      tx_reg    <= XGMII_IDLE_WORD;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      fs_reg    <= '0;
    end else begin
      state_reg <= state_next;
      words_reg <= words_next;
      rem_reg   <= rem_next;
      cnt_reg   <= cnt_next;
      cont_reg  <= cont_next;
      seed_reg  <= seed_next;
      widx_reg  <= widx_next;
      ipg_reg   <= ipg_next;
      stop_reg  <= stop_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      fs_reg    <= fs_next;
    end
  end

  assign xgmii_tx    = tx_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign frames_sent = fs_reg;

endmodule
